bne_pc_redirect: RTL and testbench

- Program-counter and fetch-redirect stage directly downstream of branchNotEqual; consumes bneFlag for a resolved BNE and steers the fetch PC.
- Holds the 16-bit fetch PC and advances it by 2 per instruction.
- On a taken BNE, loads the branch target and asserts flush for FLUSH_CYCLES cycles to kill wrong-path instructions.
- Also handles fetch stall and halt.

---
 rtl/bne_pc_redirect.sv | 129 ++++++++++++
 tb/tb_bne_pc_redirect.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bne_pc_redirect.sv
// rtl/bne_pc_redirect.sv - fetch PC register and BNE redirect/flush stage.
// Optional taken/not-taken statistics counters enabled by defining BNE_STATS_EN.
module bne_pc_redirect #(
  parameter int              WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_valid,
  input  logic             bneFlag,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_offset,
  output logic [WIDTH-1:0] pc,
  output logic             flush,
  output logic             br_taken,
  output logic             halted,
  output logic [15:0]      taken_count,
  output logic [15:0]      nottaken_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_REDIRECT,
    S_HALT
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state;
  logic [2:0]       flush_cnt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_seq;
  logic             take;

  // Offset counts instructions; two bytes each, relative to the next instruction.
  assign target = br_pc + WIDTH'(2) + (br_offset << 1);
  assign pc_seq = stall ? pc : pc + WIDTH'(2);
  assign take   = br_valid & bneFlag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      br_taken  <= 1'b0;
      halted    <= 1'b0;
      flush_cnt <= 3'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (halt) begin
            state    <= S_HALT;
            halted   <= 1'b1;
            flush    <= 1'b0;
            br_taken <= 1'b0;
          end else if (take) begin
            state     <= S_REDIRECT;
            pc        <= target;
            flush     <= 1'b1;
            br_taken  <= 1'b1;
            flush_cnt <= FLUSH_LOAD;
          end else begin
            pc       <= pc_seq;
            flush    <= 1'b0;
            br_taken <= 1'b0;
          end
        end

        S_REDIRECT: begin
          br_taken <= 1'b0;
          if (halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
            flush  <= 1'b0;
          end else begin
            // Branches seen here are on the wrong path and are dropped.
            pc <= pc_seq;
            if (flush_cnt == 3'd0) begin
              flush <= 1'b0;
              state <= S_RUN;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
        end

        S_HALT: begin
          flush    <= 1'b0;
          br_taken <= 1'b0;
          halted   <= 1'b1;
        end

        default: begin
          state    <= S_RUN;
          flush    <= 1'b0;
          br_taken <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

`ifdef BNE_STATS_EN
  logic taken_evt;
  logic nottaken_evt;

  assign taken_evt    = (state == S_RUN) & ~halt & take;
  assign nottaken_evt = (state == S_RUN) & ~halt & br_valid & ~bneFlag;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count    <= 16'd0;
      nottaken_count <= 16'd0;
    end else begin
      if (taken_evt && taken_count != 16'hFFFF)
        taken_count <= taken_count + 16'd1;
      if (nottaken_evt && nottaken_count != 16'hFFFF)
        nottaken_count <= nottaken_count + 16'd1;
    end
  end
`else
  assign taken_count    = 16'd0;
  assign nottaken_count = 16'd0;
`endif

endmodule

// File: tb/tb_bne_pc_redirect.sv
// tb/tb_bne_pc_redirect.sv - directed vector bench for bne_pc_redirect.
module tb_bne_pc_redirect;

  logic        clk = 1'b0;
  logic        rst, stall, halt, br_valid, bneFlag;
  logic [15:0] br_pc, br_offset;
  logic [15:0] pc;
  logic        flush, br_taken, halted;
  logic [15:0] taken_count, nottaken_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bne_pc_redirect #(.WIDTH(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .br_valid(br_valid), .bneFlag(bneFlag), .br_pc(br_pc), .br_offset(br_offset),
    .pc(pc), .flush(flush), .br_taken(br_taken), .halted(halted),
    .taken_count(taken_count), .nottaken_count(nottaken_count)
  );

  typedef struct {
    logic        rst, stall, halt, bv, bf;
    logic [15:0] bpc, boff;
    logic [15:0] e_pc;
    logic        e_fl, e_tk, e_h;
    logic [15:0] e_tc, e_ntc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic h, logic bv, logic bf,
                              logic [15:0] bpc, logic [15:0] boff, logic [15:0] epc,
                              logic fl, logic tk, logic hd, logic [15:0] tc, logic [15:0] ntc);
    vec_t v;
    v.rst = r; v.stall = s; v.halt = h; v.bv = bv; v.bf = bf;
    v.bpc = bpc; v.boff = boff; v.e_pc = epc;
    v.e_fl = fl; v.e_tk = tk; v.e_h = hd; v.e_tc = tc; v.e_ntc = ntc;
    return v;
  endfunction

  function automatic logic [15:0] cnt(logic [15:0] v);
`ifdef BNE_STATS_EN
    return v;
`else
    return (v == v) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(logic r, logic s, logic h, logic bv, logic bf,
                       logic [15:0] bpc, logic [15:0] boff);
    rst = r; stall = s; halt = h; br_valid = bv; bneFlag = bf;
    br_pc = bpc; br_offset = boff;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic [15:0] epc, logic fl, logic tk, logic hd,
                           logic [15:0] tc, logic [15:0] ntc);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".flush"}, 16'(flush), 16'(fl));
    check({tag, ".br_taken"}, 16'(br_taken), 16'(tk));
    check({tag, ".halted"}, 16'(halted), 16'(hd));
    check({tag, ".taken_count"}, taken_count, cnt(tc));
    check({tag, ".nottaken_count"}, nottaken_count, cnt(ntc));
  endtask

  initial begin
    int hi_cycles;
    int budget;

    // rst stall halt bv bf  br_pc     br_off    | pc       fl tk h  tc  ntc
    vecs.push_back(mk(1,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,0, 0, 0)); // 0 reset
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0002, 0,0,0, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0004, 0,0,0, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0006, 0,0,0, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0008, 0,0,0, 0, 0));
    vecs.push_back(mk(0,0,0,1,1, 16'h0010, 16'h0004, 16'h001A, 1,1,0, 1, 0)); // 5 taken
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h001C, 1,0,0, 1, 0));
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h001E, 0,0,0, 1, 0));
    vecs.push_back(mk(0,0,0,1,0, 16'h0020, 16'h0004, 16'h0020, 0,0,0, 1, 1)); // 8 not taken
    vecs.push_back(mk(0,0,0,1,1, 16'h0020, 16'hFFFC, 16'h001A, 1,1,0, 2, 1)); // 9 negative offset
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h001C, 1,0,0, 2, 1));
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h001E, 0,0,0, 2, 1));
    vecs.push_back(mk(0,1,0,1,1, 16'h0040, 16'h0002, 16'h0046, 1,1,0, 3, 1)); // 12 redirect beats stall
    vecs.push_back(mk(0,0,0,1,1, 16'h0100, 16'h0010, 16'h0048, 1,0,0, 3, 1)); // 13 ignored in flush
    vecs.push_back(mk(0,1,0,1,0, 16'h0100, 16'h0010, 16'h0048, 0,0,0, 3, 1)); // 14 ignored, stalled
    vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h0000, 16'h0048, 0,0,0, 3, 1)); // 15 stall in RUN
    vecs.push_back(mk(0,0,0,1,1, 16'hFFFA, 16'h0001, 16'hFFFE, 1,1,0, 4, 1)); // 16
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 1,0,0, 4, 1)); // 17 wrap
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0002, 0,0,0, 4, 1));
    vecs.push_back(mk(0,0,0,1,1, 16'hFFFC, 16'h0001, 16'h0000, 1,1,0, 5, 1)); // 19 target wraps
    vecs.push_back(mk(0,0,1,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,1, 5, 1)); // 20 halt in REDIRECT
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,1, 5, 1));
    vecs.push_back(mk(0,0,0,1,1, 16'h0030, 16'h0004, 16'h0000, 0,0,1, 5, 1));
    vecs.push_back(mk(0,1,0,1,0, 16'h0030, 16'h0004, 16'h0000, 0,0,1, 5, 1));
    vecs.push_back(mk(0,0,1,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,1, 5, 1));
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,1, 5, 1));
    vecs.push_back(mk(1,0,0,1,1, 16'h0030, 16'h0004, 16'h0000, 0,0,0, 0, 0)); // 26 reset from HALT
    vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0000, 16'h0002, 0,0,0, 0, 0));
    vecs.push_back(mk(0,0,1,1,1, 16'h0050, 16'h0004, 16'h0002, 0,0,1, 0, 0)); // 28 halt beats branch
    vecs.push_back(mk(1,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].halt, vecs[i].bv, vecs[i].bf,
            vecs[i].bpc, vecs[i].boff);
      check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_fl, vecs[i].e_tk,
                vecs[i].e_h, vecs[i].e_tc, vecs[i].e_ntc);
    end

    // Reset arriving mid-flush returns straight to RUN with no residual flush.
    drive(0,0,0,1,1, 16'h0010, 16'h0004);
    check_all("midflush.taken", 16'h001A, 1, 1, 0, 1, 0);
    drive(1,0,0,0,0, 16'h0000, 16'h0000);
    check_all("midflush.rst", 16'h0000, 0, 0, 0, 0, 0);
    drive(0,0,0,0,0, 16'h0000, 16'h0000);
    check_all("midflush.after", 16'h0002, 0, 0, 0, 0, 0);

    // Flush width measured with a bounded wait, under a held stall.
    drive(0,1,0,1,1, 16'h0100, 16'h0000);
    check_all("width.taken", 16'h0102, 1, 1, 0, 1, 0);
    hi_cycles = 1;
    budget = 0;
    while (flush && budget < 10) begin
      drive(0,1,0,0,0, 16'h0000, 16'h0000);
      if (flush) hi_cycles++;
      budget++;
    end
    check("width.flush_cycles", 16'(hi_cycles), 16'd2);
    check("width.pc_held", pc, 16'h0102);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
